trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of data words.
REQ-002 Parameter DEPTH, default 16, SHALL set the event FIFO entries; power of two, at least 4.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 capture_en  input  1  SHALL enable event detection when high.
REQ-006 reg_write_sig  input  1  SHALL indicate a core register write-back this cycle.
REQ-007 reg_num  input  5  SHALL carry the write-back destination register.
REQ-008 reg_data  input  DATA_W  SHALL carry the write-back value.
REQ-009 wr / rd  input  1 each  SHALL indicate a core data-memory write / read this cycle.
REQ-010 addr  input  9  SHALL carry the data-memory address.
REQ-011 wr_data / rd_data  input  DATA_W each  SHALL carry the memory write / read data.
REQ-012 ev_valid  output  1  SHALL be high while the FIFO is non-empty.
REQ-013 ev_ready  input  1  SHALL be the host accept; an event pops when ev_valid and ev_ready are both high.
REQ-014 ev_kind  output  2  SHALL carry the head kind: 00 REG, 01 MEM_RD, 10 MEM_WR, 11 reserved.
REQ-015 ev_tag  output  9  SHALL carry the head tag: zero-extended reg_num for REG, addr for MEM.
REQ-016 ev_data  output  DATA_W  SHALL carry the head data: reg_data, rd_data or wr_data.
REQ-017 ev_seq  output  16  SHALL carry the head sequence number.
REQ-018 drop_cnt  output  16  SHALL count dropped events.
REQ-019 level  output  $clog2(DEPTH)+1  SHALL carry the current FIFO occupancy.

Function
REQ-020 A REG event SHALL be detected when capture_en, reg_write_sig and reg_num!=0 are all high; writes to x0 SHALL be ignored.
REQ-021 A MEM event SHALL be detected when capture_en is high and wr or rd is high; if both are high, a MEM_WR event SHALL be detected.
REQ-022 With capture_en low, no event SHALL be detected and the sequence counter SHALL hold.
REQ-023 When REG and MEM events are detected in the same cycle, the REG event SHALL be enqueued ahead of the MEM event.
REQ-024 Free space SHALL be computed from level before that cycle's pop; a same-cycle pop SHALL NOT create room.
REQ-025 If space is 1 and two events are detected, REG SHALL be enqueued, MEM dropped, and drop_cnt incremented by 1.
REQ-026 If space is 0, all detected events SHALL be dropped and drop_cnt incremented by the count dropped.
REQ-027 drop_cnt SHALL saturate at 16'hFFFF.
REQ-028 The sequence counter SHALL advance by the number of detected events (enqueued plus dropped), wrapping modulo 2^16; each event SHALL take the next value in enqueue order, so drops appear as gaps.
REQ-029 The FIFO SHALL be first-word fall-through; an event detected in cycle N SHALL be visible at the outputs in cycle N+1.
REQ-030 Update rule: level_next = level + pushes - pop; a simultaneous push and pop at full SHALL be handled per REQ-024, with the pop applied.
REQ-031 Head outputs SHALL remain stable while ev_valid is high and ev_ready is low.
REQ-032 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-033 Asserting reset SHALL immediately clear level, the pointers, ev_valid, drop_cnt and the sequence counter to 0.
REQ-034 A reset mid-operation SHALL discard all queued events; ev_kind, ev_tag, ev_data and ev_seq SHALL read 0 while empty after reset.
REQ-035 FIFO storage SHALL NOT require reset.

Structure
REQ-036 Package trace_pkg SHALL hold the ev_kind_t enum, the trace_event_t struct {kind, tag, data, seq}, and the default DEPTH constant.
REQ-037 Storage SHALL live in one sub-module, trace_fifo, providing two write ports (in-order) and one read port; detection, sequencing and drop logic SHALL stay in trace_capture.

Verification
REQ-038 Apply reset; pulse reg_write_sig with reg_num=5, reg_data=32'h1234, ev_ready=1 -> one cycle later ev_valid=1, kind=REG, tag=5, data=32'h1234, seq=0.
REQ-039 In one cycle apply reg_num=3 together with wr=1, addr=9'h40, wr_data=32'hAA -> REG seq=0 popped first, then MEM_WR tag=9'h40 seq=1.
REQ-040 Hold ev_ready=0 and issue DEPTH-1 REG events, then one REG+MEM cycle -> level=DEPTH, drop_cnt=1, last stored seq=DEPTH-1, next detected event gets seq DEPTH+1.
REQ-041 At full with ev_ready=1, issue one REG event -> event dropped, drop_cnt increments, level becomes DEPTH-1.
REQ-042 reg_write_sig with reg_num=0, or any activity with capture_en=0 -> no enqueue and sequence counter unchanged.
REQ-043 Fill half the FIFO, then assert reset mid-cycle -> outputs clear asynchronously; after release the next event gets seq=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and defaults for the core trace capture block.
package trace_pkg;

  localparam int TRACE_DEPTH  = 16;
  localparam int TRACE_DATA_W = 32;
  localparam int TAG_W        = 9;
  localparam int SEQ_W        = 16;

  typedef enum logic [1:0] {
    EV_REG    = 2'b00,
    EV_MEM_RD = 2'b01,
    EV_MEM_WR = 2'b10,
    EV_RSVD   = 2'b11
  } ev_kind_t;

  typedef struct packed {
    ev_kind_t                  kind;
    logic [TAG_W-1:0]          tag;
    logic [TRACE_DATA_W-1:0]   data;
    logic [SEQ_W-1:0]          seq;
  } trace_event_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through event store with two in-order write ports and one read port.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push0,
  input  logic [W-1:0]               d0,
  input  logic                       push1,
  input  logic [W-1:0]               d1,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is not reset; the valid gate below hides stale contents.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= d0;
    if (push1) mem[wr_ptr + AW'(1)] <= d1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      level  <= level + LW'(push0) + LW'(push1) - LW'(pop);
    end
  end

  assign valid = (level != '0);
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/trace_capture.sv
// Detects register write-back and data-memory events, sequences them and queues them for the host.
module trace_capture
  import trace_pkg::*;
#(
  parameter int DATA_W = TRACE_DATA_W,
  parameter int DEPTH  = TRACE_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic                     reg_write_sig,
  input  logic [4:0]               reg_num,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [8:0]               addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [1:0]               ev_kind,
  output logic [8:0]               ev_tag,
  output logic [DATA_W-1:0]        ev_data,
  output logic [15:0]              ev_seq,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = 2 + TAG_W + DATA_W + SEQ_W;

  logic              reg_ev;
  logic              mem_ev;
  logic              push0;
  logic              push1;
  logic              pop;
  logic [1:0]        n_det;
  logic [1:0]        n_push;
  logic [1:0]        n_drop;
  logic [LW-1:0]     space;
  logic [SEQ_W-1:0]  seq_cnt;
  ev_kind_t          mem_kind;
  logic [DATA_W-1:0] mem_data;
  logic [EW-1:0]     reg_entry;
  logic [EW-1:0]     mem_entry;
  logic [EW-1:0]     wr_entry0;
  logic [EW-1:0]     head;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Stage p0: detection, admission against pre-pop occupancy, and sequence assignment
  always_comb begin
    reg_ev    = capture_en & reg_write_sig & (reg_num != 5'd0);
    mem_ev    = capture_en & (wr | rd);
    mem_kind  = wr ? EV_MEM_WR : EV_MEM_RD;
    mem_data  = wr ? wr_data : rd_data;
    n_det     = {1'b0, reg_ev} + {1'b0, mem_ev};
    space     = LW'(DEPTH) - level;
    push0     = (n_det != 2'd0) && (space != '0);
    push1     = reg_ev && mem_ev && (space >= LW'(2));
    n_push    = {1'b0, push0} + {1'b0, push1};
    n_drop    = n_det - n_push;
    reg_entry = {EV_REG, {4'b0000, reg_num}, reg_data, seq_cnt};
    mem_entry = {mem_kind, addr, mem_data, reg_ev ? seq_cnt + 16'd1 : seq_cnt};
    wr_entry0 = reg_ev ? reg_entry : mem_entry;
    pop       = ev_valid & ev_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      seq_cnt  <= seq_cnt + SEQ_W'(n_det);
      drop_cnt <= sat_add16(drop_cnt, n_drop);
    end
  end

  // Stage p1: queued events, head presented fall-through
  trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (push0),
    .d0    (wr_entry0),
    .push1 (push1),
    .d1    (mem_entry),
    .pop   (pop),
    .head  (head),
    .valid (ev_valid),
    .level (level)
  );

  assign {ev_kind, ev_tag, ev_data, ev_seq} = head;

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: vector table plus scoreboarded corner-case sequences.
module tb_trace_capture;
  import trace_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              capture_en;
  logic              reg_write_sig;
  logic [4:0]        reg_num;
  logic [DATA_W-1:0] reg_data;
  logic              wr;
  logic              rd;
  logic [8:0]        addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ev_valid;
  logic              ev_ready;
  logic [1:0]        ev_kind;
  logic [8:0]        ev_tag;
  logic [DATA_W-1:0] ev_data;
  logic [15:0]       ev_seq;
  logic [15:0]       drop_cnt;
  logic [LW-1:0]     level;

  trace_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .reg_write_sig(reg_write_sig),
    .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_kind(ev_kind), .ev_tag(ev_tag), .ev_data(ev_data), .ev_seq(ev_seq),
    .drop_cnt(drop_cnt), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ce;
    bit          rws;
    logic [4:0]  rn;
    logic [31:0] rdat;
    bit          w;
    bit          r;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rdd;
    bit          rdy;
    int          exp_level;
    int          exp_drop;
  } vec_t;

  int checks = 0;
  int failures = 0;
  trace_event_t sb[$];
  logic [15:0] m_seq;
  logic [15:0] m_drop;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit ce, bit rws, logic [4:0] rn, logic [31:0] rdat, bit w, bit r,
                       logic [8:0] a, logic [31:0] wd, logic [31:0] rdd, bit rdy);
    capture_en = ce; reg_write_sig = rws; reg_num = rn; reg_data = rdat;
    wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd; ev_ready = rdy;
  endtask

  task automatic model_cycle();
    int sp;
    bit do_pop;
    trace_event_t e;
    sp = DEPTH - sb.size();
    do_pop = ev_ready && (sb.size() != 0);
    if (capture_en && reg_write_sig && reg_num != 5'd0) begin
      e.kind = EV_REG; e.tag = {4'b0000, reg_num}; e.data = reg_data; e.seq = m_seq;
      if (sp > 0) begin sb.push_back(e); sp--; end
      else if (m_drop != 16'hFFFF) m_drop++;
      m_seq++;
    end
    if (capture_en && (wr || rd)) begin
      e.kind = wr ? EV_MEM_WR : EV_MEM_RD; e.tag = addr; e.data = wr ? wr_data : rd_data; e.seq = m_seq;
      if (sp > 0) begin sb.push_back(e); sp--; end
      else if (m_drop != 16'hFFFF) m_drop++;
      m_seq++;
    end
    if (do_pop) e = sb.pop_front();
  endtask

  task automatic check_state();
    chk("valid", ev_valid, sb.size() != 0);
    chk("level", level, sb.size());
    chk("drop_cnt", drop_cnt, m_drop);
    if (sb.size() != 0) begin
      chk("head_kind", ev_kind, sb[0].kind);
      chk("head_tag", ev_tag, sb[0].tag);
      chk("head_data", ev_data, sb[0].data);
      chk("head_seq", ev_seq, sb[0].seq);
    end
  endtask

  task automatic cycle();
    model_cycle();
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic check_cleared(string tag);
    chk({tag, "_valid"}, ev_valid, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
    chk({tag, "_kind"}, ev_kind, 0);
    chk({tag, "_tag"}, ev_tag, 0);
    chk({tag, "_data"}, ev_data, 0);
    chk({tag, "_seq"}, ev_seq, 0);
  endtask

  task automatic async_reset(string tag);
    #2 reset = 1'b0;
    #1 check_cleared(tag);
    sb.delete(); m_seq = '0; m_drop = '0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(string tag);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4 * DEPTH && sb.size() != 0; i++) cycle();
    chk({tag, "_drained_level"}, level, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{1, 1, 5'd5, 32'h1234, 0, 0, 9'h0,   32'h0,  32'h0,  1, 1, 0};
    vecs[1] = '{1, 0, 5'd0, 32'h0,    0, 0, 9'h0,   32'h0,  32'h0,  1, 0, 0};
    vecs[2] = '{1, 1, 5'd3, 32'h3333, 1, 0, 9'h40,  32'hAA, 32'h0,  1, 2, 0};
    vecs[3] = '{1, 0, 5'd0, 32'h0,    0, 0, 9'h0,   32'h0,  32'h0,  1, 1, 0};
    vecs[4] = '{1, 0, 5'd0, 32'h0,    0, 0, 9'h0,   32'h0,  32'h0,  1, 0, 0};
    vecs[5] = '{1, 1, 5'd0, 32'hDEAD, 0, 0, 9'h0,   32'h0,  32'h0,  1, 0, 0};
    vecs[6] = '{0, 1, 5'd7, 32'hBEEF, 0, 1, 9'h22,  32'h0,  32'h99, 1, 0, 0};
    vecs[7] = '{1, 0, 5'd0, 32'h0,    0, 1, 9'h1FF, 32'h0,  32'h55, 1, 1, 0};
    vecs[8] = '{1, 0, 5'd0, 32'h0,    1, 1, 9'h10,  32'h77, 32'h88, 1, 1, 0};
    vecs[9] = '{1, 0, 5'd0, 32'h0,    0, 0, 9'h0,   32'h0,  32'h0,  1, 0, 0};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("por");
    sb.delete(); m_seq = '0; m_drop = '0;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].ce, vecs[i].rws, vecs[i].rn, vecs[i].rdat, vecs[i].w, vecs[i].r,
            vecs[i].a, vecs[i].wd, vecs[i].rdd, vecs[i].rdy);
      cycle();
      chk($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
      chk($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].exp_drop);
    end

    // Half fill, then reset in the middle of a cycle
    for (int i = 0; i < DEPTH / 2; i++) begin
      drive(1, 1, 5'(i + 1), 32'(i), 0, 0, 0, 0, 0, 0);
      cycle();
    end
    chk("half_level", level, DEPTH / 2);
    async_reset("midrst");

    // REG and MEM_WR in the same cycle: REG first
    drive(1, 1, 5'd3, 32'h3, 1, 0, 9'h40, 32'hAA, 0, 1);
    cycle();
    chk("pair_first_kind", ev_kind, EV_REG);
    chk("pair_first_seq", ev_seq, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    chk("pair_second_kind", ev_kind, EV_MEM_WR);
    chk("pair_second_tag", ev_tag, 9'h40);
    chk("pair_second_seq", ev_seq, 1);
    drain("pair");
    @(negedge clk);
    async_reset("rst2");

    // Fill to DEPTH-1, then a REG+MEM pair with only one free slot
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1, 1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 0, 0, 0);
      cycle();
    end
    drive(1, 1, 5'd31, 32'hF00D, 0, 1, 9'h1A, 0, 32'hCAFE, 0);
    cycle();
    chk("full_level", level, DEPTH);
    chk("full_drop", drop_cnt, 1);

    // At full with a same-cycle pop: the new event still drops
    drive(1, 1, 5'd9, 32'h9, 0, 0, 0, 0, 0, 1);
    cycle();
    chk("fullpop_level", level, DEPTH - 1);
    chk("fullpop_drop", drop_cnt, 2);
    drive(1, 1, 5'd10, 32'hA, 0, 0, 0, 0, 0, 1);
    cycle();
    chk("after_gap_level", level, DEPTH - 1);
    drain("gap");

    // Saturate drop_cnt with a stalled full FIFO
    for (int i = 0; i < 2 * DEPTH && level != LW'(DEPTH); i++) begin
      drive(1, 1, 5'd2, 32'(i), 0, 0, 0, 0, 0, 0);
      cycle();
    end
    drive(1, 1, 5'd4, 32'h4, 1, 0, 9'h5, 32'h5, 0, 0);
    for (int i = 0; i < 32800; i++) cycle();
    chk("sat_drop", drop_cnt, 16'hFFFF);
    chk("sat_level", level, DEPTH);
    drain("sat");
    drive(1, 0, 0, 0, 0, 1, 9'h77, 0, 32'h1, 1);
    cycle();
    chk("wrap_level", level, 1);
    drain("wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
